// File: rtl/stack_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stack_pkg : shared types and constants for the stack arbiter     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package stack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stack_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stack_arbiter_if : requester handshake plus stack datapath bus   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface stack_arbiter_if
  import stack_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       op;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       ack;
  logic                   err;
  logic [WIDTH-1:0]       rdata;
  logic [CW-1:0]          level;
  logic                   busy;
  logic                   stk_push;
  logic                   stk_pop;
  logic [WIDTH-1:0]       stk_data_in;
  logic [WIDTH-1:0]       stk_data_out;
  logic                   stk_empty;

  // Master is the environment: requesters plus the stack itself.
  modport master (
    output req, op, wdata, stk_data_out, stk_empty,
    input  ack, err, rdata, level, busy, stk_push, stk_pop, stk_data_in
  );

  modport slave (
    input  req, op, wdata, stk_data_out, stk_empty,
    output ack, err, rdata, level, busy, stk_push, stk_pop, stk_data_in
  );

endinterface
`default_nettype wire

// File: rtl/stack_arbiter_rr_picker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_picker : combinational round-robin select, first set request  |
// | at or after ptr_i, wrapping. Rev 1.0                             |
// +------------------------------------------------------------------+
module rr_picker
  import stack_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stack_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stack_arbiter : round-robin sharing of one stack between N_REQ   |
// | push/pop requesters with occupancy tracking. Rev 1.0             |
// +------------------------------------------------------------------+
module stack_arbiter
  import stack_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic           clk,
  input  logic           reset,
  stack_arbiter_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = idx_width(N_REQ);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  state_e           state_q;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    gnt_id_q;
  logic [N_REQ-1:0] gnt_oh_q;
  logic             gnt_op_q;
  logic             err_q;
  logic [N_REQ-1:0] ack_q;
  logic             err_out_q;
  logic [WIDTH-1:0] rdata_q;
  logic [CW-1:0]    level_q;
  logic             busy_q;
  logic             push_q;
  logic             pop_q;
  logic [WIDTH-1:0] din_q;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;
  logic             pick_op;
  logic             full;
  logic             no_data;
  logic [WIDTH-1:0] wdata_a [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign wdata_a[i] = bus.wdata[i*WIDTH +: WIDTH];
  end

  rr_picker #(.N(N_REQ)) u_picker (
    .req_i   (bus.req),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign pick_op  = bus.op[pick_idx];
  assign full     = (level_q == C_FULL);
  assign no_data  = (level_q == '0) || bus.stk_empty;
  assign rr_ptr_d = (gnt_id_q == IW'(N_REQ - 1)) ? '0 : gnt_id_q + IW'(1);

  // The push/pop decision is taken on the grant edge so the registered
  // strobe is on the stack bus exactly during the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_id_q  <= '0;
      gnt_oh_q  <= '0;
      gnt_op_q  <= OP_POP;
      err_q     <= 1'b0;
      ack_q     <= '0;
      err_out_q <= 1'b0;
      rdata_q   <= '0;
      level_q   <= '0;
      busy_q    <= 1'b0;
      push_q    <= 1'b0;
      pop_q     <= 1'b0;
      din_q     <= '0;
    end else begin
      ack_q     <= '0;
      err_out_q <= 1'b0;
      push_q    <= 1'b0;
      pop_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            gnt_id_q <= pick_idx;
            gnt_oh_q <= pick_gnt;
            gnt_op_q <= pick_op;
            busy_q   <= 1'b1;
            state_q  <= ISSUE;
            if (pick_op == OP_PUSH) begin
              err_q  <= full;
              push_q <= !full;
              if (!full) din_q <= wdata_a[pick_idx];
            end else begin
              err_q <= no_data;
              pop_q <= !no_data;
            end
          end
        end
        ISSUE: begin
          if (!err_q) begin
            level_q <= (gnt_op_q == OP_PUSH) ? level_q + CW'(1) : level_q - CW'(1);
          end
          if (!err_q && gnt_op_q == OP_POP) begin
            state_q <= CAPT;
          end else begin
            state_q   <= RESP;
            ack_q     <= gnt_oh_q;
            err_out_q <= err_q;
          end
        end
        CAPT: begin
          rdata_q <= bus.stk_data_out;
          ack_q   <= gnt_oh_q;
          state_q <= RESP;
        end
        RESP: begin
          rr_ptr_q <= rr_ptr_d;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack         = ack_q;
  assign bus.err         = err_out_q;
  assign bus.rdata       = rdata_q;
  assign bus.level       = level_q;
  assign bus.busy        = busy_q;
  assign bus.stk_push    = push_q;
  assign bus.stk_pop     = pop_q;
  assign bus.stk_data_in = din_q;

endmodule
`default_nettype wire

// File: tb/tb_stack_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_stack_arbiter : table-driven scoreboard bench for the stack   |
// | arbiter with a behavioural stack. Rev 1.0                        |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_stack_arbiter;
  import stack_pkg::*;

  localparam int N = 2;
  localparam int W = 8;
  localparam int D = 4;

  typedef struct {
    int         id;
    logic       op;
    logic [7:0] wd;
    logic       eerr;
    logic [7:0] erd;
    int         elev;
    int         elat;   // 0 = latency not checked
    int         t;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stack_arbiter_if #(.N_REQ(N), .WIDTH(W), .DEPTH(D)) bus ();

  stack_arbiter #(.N_REQ(N), .WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Behavioural stack: registered data_out, valid the cycle after pop.
  logic [W-1:0] mem [8];
  logic [2:0]   sp;
  always_ff @(posedge clk) begin
    if (reset) begin
      sp               <= 3'd0;
      bus.stk_data_out <= '0;
    end else if (bus.stk_push && sp < 3'(D)) begin
      mem[sp] <= bus.stk_data_in;
      sp      <= sp + 3'd1;
    end else if (bus.stk_pop && sp != 3'd0) begin
      bus.stk_data_out <= mem[sp - 3'd1];
      sp               <= sp - 3'd1;
    end
  end
  assign bus.stk_empty = (sp == 3'd0);

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  vec_t sbq[$];
  vec_t e;
  int npush = 0;
  int npop = 0;
  int ndual = 0;
  logic [7:0] last_din = '0;

  always @(negedge clk) begin
    if (reset) begin
      npush = 0;
      npop  = 0;
      ndual = 0;
    end else begin
      if (bus.stk_push && bus.stk_pop) ndual++;
      if (bus.stk_push) begin
        npush++;
        last_din = bus.stk_data_in;
      end
      if (bus.stk_pop) npop++;
      if (|bus.ack) begin
        if (sbq.size() == 0) begin
          check("unexpected_ack", 32'(bus.ack), 32'd0);
        end else begin
          e = sbq.pop_front();
          check("ack_id", 32'(bus.ack), 32'(1 << e.id));
          check("err", 32'(bus.err), 32'(e.eerr));
          check("rdata", 32'(bus.rdata), 32'(e.erd));
          check("level", 32'(bus.level), e.elev);
          if (e.elat > 0) check("latency", cyc - e.t, e.elat);
          check("push_strobes", npush, 32'(e.op && !e.eerr));
          check("pop_strobes", npop, 32'(!e.op && !e.eerr));
          if (e.op && !e.eerr) check("stk_data_in", 32'(last_din), 32'(e.wd));
          check("dual_strobe", ndual, 32'd0);
        end
        npush = 0;
        npop  = 0;
      end
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_ack"},   32'(bus.ack), 32'd0);
    check({tag, "_err"},   32'(bus.err), 32'd0);
    check({tag, "_rdata"}, 32'(bus.rdata), 32'd0);
    check({tag, "_level"}, 32'(bus.level), 32'd0);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
    check({tag, "_push"},  32'(bus.stk_push), 32'd0);
    check({tag, "_pop"},   32'(bus.stk_pop), 32'd0);
    check({tag, "_din"},   32'(bus.stk_data_in), 32'd0);
  endtask

  task automatic txn(input vec_t v);
    vec_t x;
    int k;
    @(negedge clk);
    x = v;
    x.t = cyc;
    sbq.push_back(x);
    bus.op[v.id]            = v.op;
    bus.wdata[v.id*W +: W]  = v.wd;
    bus.req[v.id]           = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.ack[v.id] && k < 20);
    check("ack_seen", 32'(bus.ack[v.id]), 32'd1);
    bus.req[v.id] = 1'b0;
  endtask

  vec_t tbl [13];
  int acks;
  int k5;

  initial begin
    bus.req   = '0;
    bus.op    = '0;
    bus.wdata = '0;

    // fields: id, op, wdata, err, rdata, level, latency, t
    tbl[0]  = '{0, OP_POP,  8'h00, 1'b1, 8'h00, 0, 2, 0};
    tbl[1]  = '{0, OP_PUSH, 8'hA4, 1'b0, 8'h00, 1, 2, 0};
    tbl[2]  = '{1, OP_POP,  8'h00, 1'b0, 8'hA4, 0, 3, 0};
    tbl[3]  = '{0, OP_PUSH, 8'h01, 1'b0, 8'hA4, 1, 2, 0};
    tbl[4]  = '{1, OP_PUSH, 8'h02, 1'b0, 8'hA4, 2, 2, 0};
    tbl[5]  = '{0, OP_PUSH, 8'h03, 1'b0, 8'hA4, 3, 2, 0};
    tbl[6]  = '{1, OP_PUSH, 8'h04, 1'b0, 8'hA4, 4, 2, 0};
    tbl[7]  = '{0, OP_PUSH, 8'hC2, 1'b1, 8'hA4, 4, 2, 0};
    tbl[8]  = '{1, OP_POP,  8'h00, 1'b0, 8'h04, 3, 3, 0};
    tbl[9]  = '{0, OP_POP,  8'h00, 1'b0, 8'h03, 2, 3, 0};
    tbl[10] = '{1, OP_POP,  8'h00, 1'b0, 8'h02, 1, 3, 0};
    tbl[11] = '{0, OP_POP,  8'h00, 1'b0, 8'h01, 0, 3, 0};
    tbl[12] = '{1, OP_POP,  8'h00, 1'b1, 8'h01, 0, 2, 0};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;

    for (int i = 0; i < 13; i++) txn(tbl[i]);

    // Both requesters pushing continuously: grants must alternate 0,1,0,1.
    @(negedge clk);
    sbq.push_back('{0, OP_PUSH, 8'h11, 1'b0, 8'h01, 1, 0, 0});
    sbq.push_back('{1, OP_PUSH, 8'h22, 1'b0, 8'h01, 2, 0, 0});
    sbq.push_back('{0, OP_PUSH, 8'h11, 1'b0, 8'h01, 3, 0, 0});
    sbq.push_back('{1, OP_PUSH, 8'h22, 1'b0, 8'h01, 4, 0, 0});
    bus.op    = 2'b11;
    bus.wdata = {8'h22, 8'h11};
    bus.req   = 2'b11;
    acks = 0;
    k5   = 0;
    while (acks < 4 && k5 < 40) begin
      @(negedge clk);
      k5++;
      if (|bus.ack) acks++;
    end
    bus.req = '0;
    check("rr_ack_count", acks, 32'd4);

    // Reset while a pop sits in CAPT: no ack, everything cleared.
    @(negedge clk);
    bus.op[0]  = OP_POP;
    bus.req[0] = 1'b1;
    @(negedge clk);
    check("abort_issue_pop", 32'(bus.stk_pop), 32'd1);
    @(negedge clk);
    check("abort_capt_busy", 32'(bus.busy), 32'd1);
    reset   = 1'b1;
    bus.req = '0;
    @(negedge clk);
    check_idle("abort");
    reset = 1'b0;
    txn('{0, OP_PUSH, 8'hC2, 1'b0, 8'h00, 1, 2, 0});

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
Shares one `stack` instance between N_REQ requesters. Each requester issues a push or pop request with a req/ack handshake. The block grants requesters round-robin and drives the stack's push/pop/data_in for exactly one cycle per transaction. It returns popped data, tracks occupancy to refuse push-when-full and pop-when-empty, and sits between client logic and the `stack` datapath.

Parameters:
N_REQ, 2, number of requesters (2..8)
WIDTH, 8, data width; matches stack data_in/data_out
DEPTH, 16, stack capacity in entries; used for full detection
CW, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req  input  N_REQ  per-requester request; held high until matching ack
op  input  N_REQ  per-requester operation: 1=push, 0=pop; stable while req high
wdata  input  N_REQ*WIDTH  push data; requester i at [i*WIDTH +: WIDTH]; stable while req high
ack  output  N_REQ  one-cycle completion pulse to the granted requester
err  output  1  valid with ack; 1 = refused (push when full or pop when empty)
rdata  output  WIDTH  popped data; valid with ack for a successful pop, else holds last value
level  output  CW  current stack occupancy, 0..DEPTH
busy  output  1  high whenever FSM is not IDLE
stk_push  output  1  to stack push
stk_pop  output  1  to stack pop
stk_data_in  output  WIDTH  to stack data_in
stk_data_out  input  WIDTH  from stack data_out; registered, valid the cycle after stk_pop
stk_empty  input  1  from stack empty

Behaviour:
- Reset (sync, high): state=IDLE, ack=0, err=0, rdata=0, level=0, busy=0, stk_push=0, stk_pop=0, stk_data_in=0, rr_ptr=0. The same reset line clears the stack. Reset mid-transaction aborts it with no ack.
- FSM states: IDLE, ISSUE, CAPT, RESP.
- IDLE:
  - If any req bit is set, grant the first set bit starting at rr_ptr, wrapping modulo N_REQ.
  - Latch gnt_id, gnt_op and the granted wdata slice; go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE (one cycle):
  - Push with level==DEPTH: no stack strobe, set err_q=1, go to RESP.
  - Pop with (level==0 or stk_empty==1): no stack strobe, set err_q=1, go to RESP.
  - Successful push: stk_push=1, stk_data_in=latched data, level+1, go to RESP.
  - Successful pop: stk_pop=1, level-1, go to CAPT.
  - stk_push and stk_pop are never high together, and each is high at most one cycle per transaction.
- CAPT: register stk_data_out into rdata; go to RESP.
- RESP: ack[gnt_id]=1 and err=err_q for exactly one cycle; rr_ptr=(gnt_id+1) mod N_REQ; go to IDLE.
- Latency, from the IDLE cycle in which req is sampled to the ack cycle: push or error = 2 cycles; successful pop = 3 cycles.
- Requester handshake: drop req in the ack cycle. If req is still high in the following IDLE, it is treated as a new request.
- A requester that drops req before ack still completes; its ack is issued and ignored.
- Requests arriving while busy wait; no request is lost while its req is held.
- Round-robin fairness: with all requesters asserting continuously, grants rotate 0,1,..,N_REQ-1,0.
- level never leaves 0..DEPTH. Errors do not change level.

Decomposition:
- Shared package `stack_pkg`:
  - state enum (IDLE/ISSUE/CAPT/RESP)
  - OP_PUSH=1, OP_POP=0 constants
  - default WIDTH/DEPTH
- One natural sub-module, `rr_picker`: combinational round-robin priority select (req vector + rr_ptr -> one-hot grant + index), reusable by other arbiters.
- FSM, occupancy counter and data latch live in stack_arbiter.

Test Plan:
1. Reset, then req[0]=1, op=push, wdata0=8'hA4 -> stk_push one cycle with stk_data_in=8'hA4; ack[0] 2 cycles after grant; err=0; level=1.
2. Continuing from 1: req[1]=1, op=pop -> stk_pop one cycle; ack[1] 3 cycles after grant; rdata=8'hA4; err=0; level=0.
3. Pop with stack empty after reset -> no stk_pop; ack 2 cycles later with err=1; level stays 0; rdata unchanged.
4. DEPTH=4: four pushes 8'h01..8'h04, then a fifth push 8'hC2 -> fifth ack has err=1, no stk_push, level=4. Then four pops return 8'h04,8'h03,8'h02,8'h01.
5. req[0] and req[1] both held high with pushes 8'h11/8'h22 -> grants alternate 0,1,0,1; stack receives 11,22,11,22; level increments by 1 per ack.
6. Assert reset during CAPT of a pop -> no ack; next cycle state IDLE, level=0, all outputs 0; a following push of 8'hC2 completes normally with level=1.
